// File: rtl/pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : pipeline_hazard_ctrl
//  Purpose  : Central hazard controller for the 5-stage RV32I pipeline.
//             Detects load-use hazards, sequences taken-branch flushes and
//             data-memory wait stalls, selects EX operand forwarding, and
//             keeps saturating stall/flush counters plus a sticky
//             memory-timeout flag.
//  Ports    : clk, rst                    clock / sync active-high reset
//             i_id_rs1/2, i_id_use_rs1/2  ID-stage source registers and usage
//             i_ex_rd, i_ex_load          EX destination, EX is a load
//             i_ex_rs1/2, i_ex_taken      EX sources, branch/jump taken
//             i_mem_rd/we, i_wb_rd/we     EX/MEM and MEM/WB writeback info
//             i_dmem_req, i_dmem_ready    data-memory handshake
//             o_pc_we, o_ifid_we          PC / IF-ID write enables
//             o_ifid_flush, o_idex_flush  flush controls
//             o_idex_bubble, o_pipe_hold  bubble insert / back-end freeze
//             o_fwd_a/b                   10 EX/MEM, 01 MEM/WB, 00 reg file
//             o_stall_cnt, o_flush_cnt    saturating performance counters
//             o_mem_timeout               sticky memory-wait timeout
//  Revision : 1.0  initial release
// ============================================================================
module pipeline_hazard_ctrl #(
    parameter int CNT_W        = 16,
    parameter int WAIT_TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       i_id_rs1,
    input  logic [4:0]       i_id_rs2,
    input  logic             i_id_use_rs1,
    input  logic             i_id_use_rs2,
    input  logic [4:0]       i_ex_rd,
    input  logic             i_ex_load,
    input  logic [4:0]       i_ex_rs1,
    input  logic [4:0]       i_ex_rs2,
    input  logic             i_ex_taken,
    input  logic [4:0]       i_mem_rd,
    input  logic             i_mem_we,
    input  logic [4:0]       i_wb_rd,
    input  logic             i_wb_we,
    input  logic             i_dmem_req,
    input  logic             i_dmem_ready,
    output logic             o_pc_we,
    output logic             o_ifid_we,
    output logic             o_ifid_flush,
    output logic             o_idex_bubble,
    output logic             o_idex_flush,
    output logic             o_pipe_hold,
    output logic [1:0]       o_fwd_a,
    output logic [1:0]       o_fwd_b,
    output logic [CNT_W-1:0] o_stall_cnt,
    output logic [CNT_W-1:0] o_flush_cnt,
    output logic             o_mem_timeout
);

    // Wait counter only needs to reach WAIT_TIMEOUT-1: the timeout fires
    // at the end of the MEM_WAIT cycle that starts with that value.
    localparam int                 c_WCNT_W    = (WAIT_TIMEOUT < 2) ? 1 : $clog2(WAIT_TIMEOUT);
    localparam logic [c_WCNT_W-1:0] c_WAIT_LAST = c_WCNT_W'(WAIT_TIMEOUT - 1);

    typedef enum logic [0:0] {
        S_RUN      = 1'b0,
        S_MEM_WAIT = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [c_WCNT_W-1:0] r_wait_cnt;
    logic [CNT_W-1:0]    r_stall_cnt;
    logic [CNT_W-1:0]    r_flush_cnt;
    logic                r_mem_timeout;

    logic                w_load_use;
    logic                w_mem_wait;
    logic                w_flush_evt;

    assign w_load_use = i_ex_load && (i_ex_rd != 5'd0) &&
                        ((i_id_use_rs1 && (i_id_rs1 == i_ex_rd)) ||
                         (i_id_use_rs2 && (i_id_rs2 == i_ex_rd)));

    // The ready cycle inside MEM_WAIT is still a hold cycle.
    assign w_mem_wait = (r_state == S_MEM_WAIT) || (i_dmem_req && !i_dmem_ready);

    // ------------------------------------------------------------------
    // Next state and pipeline controls, priority: wait > flush > load-use
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt   = r_state;
        o_pc_we       = 1'b1;
        o_ifid_we     = 1'b1;
        o_ifid_flush  = 1'b0;
        o_idex_bubble = 1'b0;
        o_idex_flush  = 1'b0;
        o_pipe_hold   = 1'b0;
        w_flush_evt   = 1'b0;

        case (r_state)
            S_RUN:      if (i_dmem_req && !i_dmem_ready) w_state_nxt = S_MEM_WAIT;
            S_MEM_WAIT: if (i_dmem_ready)                w_state_nxt = S_RUN;
            default:                                     w_state_nxt = S_RUN;
        endcase

        if (rst) begin
            w_state_nxt   = S_RUN;
            o_pc_we       = 1'b0;
            o_ifid_we     = 1'b0;
            o_ifid_flush  = 1'b1;
            o_idex_bubble = 1'b1;
            o_idex_flush  = 1'b1;
        end else if (w_mem_wait) begin
            // A taken branch stays asserted through the wait and is
            // acted on once the back end advances again.
            o_pc_we       = 1'b0;
            o_ifid_we     = 1'b0;
            o_pipe_hold   = 1'b1;
            o_idex_bubble = 1'b1;
        end else if (i_ex_taken) begin
            // Any load-use on the ID instruction is moot: it gets killed.
            o_ifid_flush  = 1'b1;
            o_idex_flush  = 1'b1;
            w_flush_evt   = 1'b1;
        end else if (w_load_use) begin
            o_pc_we       = 1'b0;
            o_ifid_we     = 1'b0;
            o_idex_bubble = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Operand forwarding; x0 is never forwarded, EX/MEM beats MEM/WB
    // ------------------------------------------------------------------
    always_comb begin
        o_fwd_a = 2'b00;
        o_fwd_b = 2'b00;
        if (!rst) begin
            if (i_mem_we && (i_mem_rd != 5'd0) && (i_mem_rd == i_ex_rs1))
                o_fwd_a = 2'b10;
            else if (i_wb_we && (i_wb_rd != 5'd0) && (i_wb_rd == i_ex_rs1))
                o_fwd_a = 2'b01;

            if (i_mem_we && (i_mem_rd != 5'd0) && (i_mem_rd == i_ex_rs2))
                o_fwd_b = 2'b10;
            else if (i_wb_we && (i_wb_rd != 5'd0) && (i_wb_rd == i_ex_rs2))
                o_fwd_b = 2'b01;
        end
    end

    // ------------------------------------------------------------------
    // State, wait counter, timeout and performance counters
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_RUN;
            r_wait_cnt    <= '0;
            r_stall_cnt   <= '0;
            r_flush_cnt   <= '0;
            r_mem_timeout <= 1'b0;
        end else begin
            r_state <= w_state_nxt;

            if (r_state == S_MEM_WAIT) begin
                if (r_wait_cnt != c_WAIT_LAST)
                    r_wait_cnt <= r_wait_cnt + 1'b1;
                else
                    r_mem_timeout <= 1'b1;
            end else if (w_state_nxt == S_MEM_WAIT) begin
                r_wait_cnt <= '0;
            end

            if (!o_pc_we && (r_stall_cnt != {CNT_W{1'b1}}))
                r_stall_cnt <= r_stall_cnt + 1'b1;
            if (w_flush_evt && (r_flush_cnt != {CNT_W{1'b1}}))
                r_flush_cnt <= r_flush_cnt + 1'b1;
        end
    end

    assign o_stall_cnt   = r_stall_cnt;
    assign o_flush_cnt   = r_flush_cnt;
    assign o_mem_timeout = r_mem_timeout;

endmodule
`default_nettype wire
